// File: rtl/fetch_sequencer.sv
// Fetch-stage control sequencer: streams a program image into the instruction
// cache, then drives PC/IF enables, branch redirect, wrong-path flush and halt.
module fetch_sequencer #(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        load_last,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt,
  output logic        pc_src,
  output logic [31:0] redirect_pc,
  output logic        en_pc,
  output logic        en_if,
  output logic        flush,
  output logic        w_en,
  output logic [31:0] w_addr,
  output logic [31:0] w_data,
  output logic        misalign,
  output logic        running
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH_WORDS - 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_FLUSH,
    S_HALTED
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_load_ptr;
  logic            r_misalign;
  logic            w_accept;
  logic            w_load_done;
  logic            w_redirect;

  assign w_accept    = (r_state == S_LOAD) && load_valid;
  assign w_load_done = load_last || (r_load_ptr == PTR_LAST);
  // A redirect is taken only from RUN and only when halt does not override it.
  assign w_redirect  = (r_state == S_RUN) && !halt && branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_LOAD;
      r_load_ptr <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_misalign <= w_redirect && (branch_target[1:0] != 2'b00);
      if (w_accept) begin
        r_load_ptr <= w_load_done ? '0 : r_load_ptr + PTR_ONE;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    load_ready = 1'b0;
    en_pc      = 1'b0;
    en_if      = 1'b0;
    flush      = 1'b0;
    pc_src     = 1'b0;
    w_en       = 1'b0;
    case (r_state)
      S_LOAD: begin
        load_ready = 1'b1;
        flush      = 1'b1;
        w_en       = load_valid;
        if (w_accept && w_load_done) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (halt) begin
          flush  = 1'b1;
          w_next = S_HALTED;
        end else if (branch_taken) begin
          pc_src = 1'b1;
          en_pc  = 1'b1;
          w_next = S_FLUSH;
        end else begin
          en_pc = !stall;
          en_if = !stall;
        end
      end
      S_FLUSH: begin
        flush = 1'b1;
        en_pc = !stall;
        en_if = !stall;
        if (halt) begin
          w_next = S_HALTED;
        end else if (!stall) begin
          w_next = S_RUN;
        end
      end
      S_HALTED: begin
        flush = 1'b1;
        if (load_valid) begin
          w_next = S_LOAD;
        end
      end
      default: w_next = S_LOAD;
    endcase
  end

  assign redirect_pc = {branch_target[31:2], 2'b00};
  assign w_addr      = {{(30 - AW){1'b0}}, r_load_ptr, 2'b00};
  assign w_data      = load_data;
  assign misalign    = r_misalign;
  assign running     = (r_state == S_RUN) || (r_state == S_FLUSH);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a mode-level reference model.
module tb_fetch_sequencer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        halt = 1'b0;
  logic        pc_src;
  logic [31:0] redirect_pc;
  logic        en_pc;
  logic        en_if;
  logic        flush;
  logic        w_en;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        misalign;
  logic        running;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which activity the sequencer is in, words taken so far.
  bit          m_ok = 1'b0;
  bit          m_loading, m_halted, m_squash, m_mis;
  int unsigned m_cnt;

  fetch_sequencer #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
    .pc_src(pc_src), .redirect_pc(redirect_pc), .en_pc(en_pc), .en_if(en_if),
    .flush(flush), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .misalign(misalign), .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic e_ready, e_pcsrc, e_enpc, e_enif, e_flush, e_wen, e_run;
    logic [31:0] e_addr;
    e_ready = 0; e_pcsrc = 0; e_enpc = 0; e_enif = 0; e_flush = 1; e_wen = 0; e_run = 0;
    e_addr  = 32'(m_cnt * 4);
    if (m_loading) begin
      e_ready = 1;
      e_wen   = load_valid;
    end else if (!m_halted) begin
      e_run = 1;
      if (m_squash) begin
        e_enpc = !stall;
        e_enif = !stall;
      end else if (halt) begin
        e_flush = 1;
      end else if (branch_taken) begin
        e_flush = 0;
        e_pcsrc = 1;
        e_enpc  = 1;
      end else begin
        e_flush = 0;
        e_enpc  = !stall;
        e_enif  = !stall;
      end
    end
    chk("m_load_ready", 32'(load_ready), 32'(e_ready));
    chk("m_pc_src",     32'(pc_src),     32'(e_pcsrc));
    chk("m_en_pc",      32'(en_pc),      32'(e_enpc));
    chk("m_en_if",      32'(en_if),      32'(e_enif));
    chk("m_flush",      32'(flush),      32'(e_flush));
    chk("m_w_en",       32'(w_en),       32'(e_wen));
    chk("m_w_addr",     w_addr,          e_addr);
    chk("m_w_data",     w_data,          load_data);
    chk("m_redirect",   redirect_pc,     branch_target & 32'hFFFF_FFFC);
    chk("m_misalign",   32'(misalign),   32'(m_mis));
    chk("m_running",    32'(running),    32'(e_run));
  endtask

  task automatic model_update();
    bit nm;
    nm = 0;
    if (rst) begin
      m_ok = 1; m_loading = 1; m_halted = 0; m_squash = 0; m_cnt = 0; m_mis = 0;
    end else if (m_ok) begin
      if (m_loading) begin
        if (load_valid) begin
          if (load_last || m_cnt == DEPTH - 1) begin
            m_loading = 0;
            m_cnt     = 0;
          end else begin
            m_cnt++;
          end
        end
      end else if (m_halted) begin
        if (load_valid) begin
          m_halted  = 0;
          m_loading = 1;
        end
      end else if (m_squash) begin
        if (halt) begin
          m_squash = 0;
          m_halted = 1;
        end else if (!stall) begin
          m_squash = 0;
        end
      end else if (halt) begin
        m_halted = 1;
      end else if (branch_taken) begin
        m_squash = 1;
        nm = (branch_target[1:0] != 2'b00);
      end
      m_mis = nm;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    if (m_ok) model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic set_in(input logic v, input logic [31:0] d, input logic l, input logic s,
                        input logic b, input logic [31:0] t, input logic h);
    load_valid = v; load_data = d; load_last = l; stall = s;
    branch_taken = b; branch_target = t; halt = h;
  endtask

  initial begin
    // T1: reset, then three-word image ending on load_last
    rst = 1;
    cyc(); cyc();
    rst = 0;
    sample();
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    chk("rst_flush",      32'(flush),      32'd1);
    chk("rst_running",    32'(running),    32'd0);
    chk("rst_misalign",   32'(misalign),   32'd0);
    chk("rst_w_addr",     w_addr,          32'd0);
    advance();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 32'hA + 32'(i), (i == 2), 0, 0, 0, 0);
      sample();
      chk("t1_w_en",   32'(w_en), 32'd1);
      chk("t1_w_addr", w_addr,    32'(i * 4));
      chk("t1_w_data", w_data,    32'hA + 32'(i));
      advance();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("t1_ready_off", 32'(load_ready), 32'd0);
    chk("t1_running",   32'(running),    32'd1);
    advance();

    // T3: aligned branch redirect and one-cycle squash
    set_in(0, 0, 0, 0, 1, 32'h40, 0);
    sample();
    chk("t3_pc_src",   32'(pc_src), 32'd1);
    chk("t3_en_pc",    32'(en_pc),  32'd1);
    chk("t3_redirect", redirect_pc, 32'h40);
    advance();
    set_in(0, 0, 0, 0, 0, 32'h40, 0);
    sample();
    chk("t3_flush",    32'(flush),    32'd1);
    chk("t3_pc_src0",  32'(pc_src),   32'd0);
    chk("t3_mis0",     32'(misalign), 32'd0);
    advance();
    sample();
    chk("t3_flush_off", 32'(flush), 32'd0);
    advance();

    // T4: stalled misaligned branch, squash held by stall
    set_in(0, 0, 0, 1, 1, 32'h42, 0);
    sample();
    chk("t4_en_pc",    32'(en_pc), 32'd1);
    chk("t4_redirect", redirect_pc, 32'h40);
    advance();
    set_in(0, 0, 0, 1, 0, 32'h42, 0);
    sample();
    chk("t4_misalign", 32'(misalign), 32'd1);
    chk("t4_flush_a",  32'(flush),    32'd1);
    chk("t4_en_pc_a",  32'(en_pc),    32'd0);
    advance();
    sample();
    chk("t4_flush_b",  32'(flush),    32'd1);
    chk("t4_en_pc_b",  32'(en_pc),    32'd0);
    chk("t4_mis_off",  32'(misalign), 32'd0);
    advance();
    stall = 0;
    sample();
    chk("t4_flush_c",  32'(flush), 32'd1);
    chk("t4_en_pc_c",  32'(en_pc), 32'd1);
    advance();
    sample();
    chk("t4_flush_d",  32'(flush), 32'd0);
    advance();

    // T5: halt beats branch; reload begins from HALTED
    set_in(0, 0, 0, 0, 1, 32'h80, 1);
    sample();
    chk("t5_en_pc", 32'(en_pc),  32'd0);
    chk("t5_flush", 32'(flush),  32'd1);
    chk("t5_pcsrc", 32'(pc_src), 32'd0);
    advance();
    set_in(1, 32'h11, 0, 0, 0, 0, 0);
    sample();
    chk("t5_halt_ready", 32'(load_ready), 32'd0);
    chk("t5_halt_wen",   32'(w_en),       32'd0);
    chk("t5_halt_run",   32'(running),    32'd0);
    advance();
    sample();
    chk("t5_wen",   32'(w_en),       32'd1);
    chk("t5_waddr", w_addr,          32'd0);
    chk("t5_ready", 32'(load_ready), 32'd1);
    advance();

    // T6: reset in the middle of a load restarts at word 0
    set_in(1, 32'h22, 0, 0, 0, 0, 0);
    sample();
    chk("t6_waddr_pre", w_addr, 32'd4);
    advance();
    rst = 1;
    cyc();
    rst = 0;
    set_in(1, 32'h99, 0, 0, 0, 0, 0);
    sample();
    chk("t6_waddr", w_addr,          32'd0);
    chk("t6_wen",   32'(w_en),       32'd1);
    chk("t6_ready", 32'(load_ready), 32'd1);
    chk("t6_flush", 32'(flush),      32'd1);
    chk("t6_en_pc", 32'(en_pc),      32'd0);
    chk("t6_en_if", 32'(en_if),      32'd0);
    advance();

    // T2: image fills the cache without load_last; extra words refused
    rst = 1;
    cyc();
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      set_in(1, 32'h100 + 32'(i), 0, 0, 0, 0, 0);
      sample();
      if (i < 4) begin
        chk("t2_w_en",   32'(w_en), 32'd1);
        chk("t2_w_addr", w_addr,    32'(i * 4));
      end else begin
        chk("t2_full_ready", 32'(load_ready), 32'd0);
        chk("t2_full_wen",   32'(w_en),       32'd0);
      end
      advance();
    end

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst           = ($urandom_range(0, 299) == 0);
      load_valid    = ($urandom_range(0, 1) == 1);
      load_data     = $urandom;
      load_last     = ($urandom_range(0, 3) == 0);
      stall         = ($urandom_range(0, 2) == 0);
      branch_taken  = ($urandom_range(0, 4) == 0);
      branch_target = $urandom;
      halt          = ($urandom_range(0, 19) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
